// File: rtl/seg_pkg.sv
// Shared seven-segment definitions.
// Segment bit order: bit6=a, bit5=b, bit4=c, bit3=d, bit2=e, bit1=f, bit0=g.
// Holds the hex font patterns (active-high) and the blank pattern.
package seg_pkg;

  localparam int SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_t;

  localparam seg_t SEG_0     = 7'h7E;
  localparam seg_t SEG_1     = 7'h30;
  localparam seg_t SEG_2     = 7'h6D;
  localparam seg_t SEG_3     = 7'h79;
  localparam seg_t SEG_4     = 7'h33;
  localparam seg_t SEG_5     = 7'h5B;
  localparam seg_t SEG_6     = 7'h5F;
  localparam seg_t SEG_7     = 7'h70;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h7B;
  localparam seg_t SEG_A     = 7'h77;
  localparam seg_t SEG_B     = 7'h1F;
  localparam seg_t SEG_C     = 7'h4E;
  localparam seg_t SEG_D     = 7'h3D;
  localparam seg_t SEG_E     = 7'h4F;
  localparam seg_t SEG_F     = 7'h47;
  localparam seg_t SEG_BLANK = 7'h00;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational inverse of the hex seven-segment font.
// Ports:
//   pattern - active-high segment pattern (bit6=a .. bit0=g)
//   nibble  - decoded hex value, 0 when not a font entry
//   hit     - pattern is one of the 16 font entries
//   blank   - pattern is all segments off
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [3:0]       nibble,
  output logic             hit,
  output logic             blank
);

  always_comb begin
    {hit, nibble} = 5'h00;
    unique case (pattern)
      SEG_0:   {hit, nibble} = 5'h10;
      SEG_1:   {hit, nibble} = 5'h11;
      SEG_2:   {hit, nibble} = 5'h12;
      SEG_3:   {hit, nibble} = 5'h13;
      SEG_4:   {hit, nibble} = 5'h14;
      SEG_5:   {hit, nibble} = 5'h15;
      SEG_6:   {hit, nibble} = 5'h16;
      SEG_7:   {hit, nibble} = 5'h17;
      SEG_8:   {hit, nibble} = 5'h18;
      SEG_9:   {hit, nibble} = 5'h19;
      SEG_A:   {hit, nibble} = 5'h1A;
      SEG_B:   {hit, nibble} = 5'h1B;
      SEG_C:   {hit, nibble} = 5'h1C;
      SEG_D:   {hit, nibble} = 5'h1D;
      SEG_E:   {hit, nibble} = 5'h1E;
      SEG_F:   {hit, nibble} = 5'h1F;
      default: {hit, nibble} = 5'h00;
    endcase
  end

  assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers hex digits from a scanned seven-segment bus.
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   seg_in        - segment bus (bit6=a .. bit0=g), asynchronous to clk
//   dig_in        - digit select, one-hot when valid, asynchronous to clk
//   digits_out    - decoded nibbles, digit i at [4i+3:4i]
//   digit_valid   - digit i holds a successfully decoded value
//   digit_err     - last capture of digit i was an unrecognised pattern
//   update_pulse  - one-cycle pulse on every capture
//   frame_done    - one-cycle pulse when all digits captured since last frame
module seg_scan_decoder
  import seg_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned STABLE_CYCLES  = 8,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          DIG_ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [SEG_W-1:0]        seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_in,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    update_pulse,
  output logic                    frame_done
);

  localparam logic [7:0] CntMax = 8'(STABLE_CYCLES);

  seg_t                    seg_s1_q, seg_s2_q, seg_prev_q, seg_cur;
  logic [NUM_DIGITS-1:0]   dig_s1_q, dig_s2_q, dig_prev_q, dig_cur;
  logic [7:0]              cnt_q, cnt_d;
  logic                    armed_q, armed_d;
  logic [NUM_DIGITS-1:0]   mask_q, mask_d, mask_set;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d, err_q, err_d;
  logic                    upd_q, upd_d, frame_q, frame_d;
  logic                    changed, dig_ok, capture;
  logic [3:0]              dec_nibble;
  logic                    dec_hit, dec_blank;

  // Two-flop synchronisers on the raw bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_s1_q <= '0;
      seg_s2_q <= '0;
      dig_s1_q <= '0;
      dig_s2_q <= '0;
    end else begin
      seg_s1_q <= seg_in;
      seg_s2_q <= seg_s1_q;
      dig_s1_q <= dig_in;
      dig_s2_q <= dig_s1_q;
    end
  end

  assign seg_cur = seg_s2_q ^ {SEG_W{SEG_ACTIVE_LOW}};
  assign dig_cur = dig_s2_q ^ {NUM_DIGITS{DIG_ACTIVE_LOW}};

  assign changed = ({seg_cur, dig_cur} != {seg_prev_q, dig_prev_q});
  assign dig_ok  = $onehot(dig_cur);
  // cnt_q only reaches CntMax when prev holds a dwell of a one-hot select.
  assign capture = armed_q && (cnt_q == CntMax) && $onehot(dig_prev_q);

  always_comb begin
    cnt_d   = cnt_q;
    armed_d = armed_q;
    if (capture) armed_d = 1'b0;
    if (!dig_ok) begin
      cnt_d   = '0;
      armed_d = 1'b1;
    end else if (changed) begin
      cnt_d   = 8'd1;
      armed_d = 1'b1;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  seg_pattern_decode u_decode (
    .pattern (seg_prev_q),
    .nibble  (dec_nibble),
    .hit     (dec_hit),
    .blank   (dec_blank)
  );

  assign mask_set = mask_q | dig_prev_q;

  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    err_d    = err_q;
    mask_d   = mask_q;
    upd_d    = capture;
    frame_d  = 1'b0;
    if (capture) begin
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (dig_prev_q[i]) begin
          if (dec_hit) begin
            digits_d[4*i +: 4] = dec_nibble;
            valid_d[i]         = 1'b1;
            err_d[i]           = 1'b0;
          end else begin
            valid_d[i] = 1'b0;
            err_d[i]   = !dec_blank;
          end
        end
      end
      if (&mask_set) begin
        frame_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d = mask_set;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_prev_q <= '0;
      dig_prev_q <= '0;
      cnt_q      <= '0;
      armed_q    <= 1'b1;
      mask_q     <= '0;
      digits_q   <= '0;
      valid_q    <= '0;
      err_q      <= '0;
      upd_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      seg_prev_q <= seg_cur;
      dig_prev_q <= dig_cur;
      cnt_q      <= cnt_d;
      armed_q    <= armed_d;
      mask_q     <= mask_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      upd_q      <= upd_d;
      frame_q    <= frame_d;
    end
  end

  assign digits_out   = digits_q;
  assign digit_valid  = valid_q;
  assign digit_err    = err_q;
  assign update_pulse = upd_q;
  assign frame_done   = frame_q;

endmodule

// File: doc/seg_scan_decoder.md
Name: seg_scan_decoder

Overview:
Recovers hex digit values from a multiplexed (scanned) seven-segment bus: a segment pattern plus a one-hot digit select.
- Inverse of the team's hex-to-segment font; used to check display drivers in-system and to capture readouts from external scanned displays.
- Synchronises and debounces the bus, then decodes each stable pattern back to a nibble.
- Holds per-digit value, valid and error flags, and pulses on updates and on complete frames.

Parameters:
NUM_DIGITS, 4, number of scanned digit positions (1..8)
STABLE_CYCLES, 8, consecutive identical synchronised samples required before capture (2..255)
SEG_ACTIVE_LOW, 0, 1 = segment bus is active-low; normalised internally to active-high
DIG_ACTIVE_LOW, 0, 1 = digit select is active-low; normalised internally to active-high

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
seg_in  in  7  segment bus; bit6=a, bit5=b, ..., bit0=g; asynchronous to clk
dig_in  in  NUM_DIGITS  digit select, one-hot when valid; asynchronous to clk
digits_out  out  4*NUM_DIGITS  decoded nibbles; digit i at [4i+3:4i]
digit_valid  out  NUM_DIGITS  1 = digit i holds a successfully decoded value
digit_err  out  NUM_DIGITS  1 = last capture of digit i was an unrecognised pattern
update_pulse  out  1  one-cycle pulse on any capture
frame_done  out  1  one-cycle pulse when every digit has been captured since the last frame_done

Behaviour:
- Reset (async assert, sync-style deassert via registers): all outputs 0, synchroniser stages 0, stability counter 0, captured-mask 0, armed=1.
- Synchroniser: seg_in and dig_in each pass through two flops, then polarity is normalised.
- Sample qualification: the synchronised dig must be exactly one-hot. If it is zero-hot or multi-hot:
  - the stability counter clears;
  - armed is set;
  - nothing is captured.
- Stability counter:
  - Increments (saturating at STABLE_CYCLES) while the synchronised {seg,dig} equals the previous cycle's value.
  - Reloads to 1 on any change.
- Capture:
  - Fires on the cycle the counter reaches STABLE_CYCLES while armed. armed then clears, so there is exactly one capture per dwell.
  - armed sets again on any change of {seg,dig}.
  - Latency: outputs update on the edge STABLE_CYCLES+2 clocks after the first edge that samples the new input pair.
- Decode on capture, for digit k = index of the active select bit:
  - Pattern matches a font entry → digits_out[k]=nibble, digit_valid[k]=1, digit_err[k]=0.
  - Pattern 0x00 (blank) → digit_valid[k]=0, digit_err[k]=0, nibble held.
  - Any other pattern → digit_valid[k]=0, digit_err[k]=1, nibble held.
  - update_pulse=1 for one cycle on every capture, including blank and error captures.
- Font table (7-bit pattern → nibble): 7E→0, 30→1, 6D→2, 79→3, 33→4, 5B→5, 5F→6, 70→7, 7F→8, 7B→9, 77→A, 1F→B, 4E→C, 3D→D, 4F→E, 47→F.
- Frame tracking:
  - Each capture sets captured-mask[k].
  - When the mask becomes all-ones, frame_done pulses with that capture and the mask clears in the same cycle.
  - Repeated captures of the same digit within a frame are allowed and do not advance the frame.
- Other digits' outputs are never disturbed by a capture.
- Reset mid-dwell: all state clears immediately; after release, capture requires a full new dwell.
- Input glitch shorter than STABLE_CYCLES: no capture, no pulses. If the bus then returns to its prior value, armed is set and a new dwell captures again.

Decomposition:
- Shared package seg_pkg:
  - SEG_W=7;
  - the 16 font pattern constants (SEG_0..SEG_F);
  - SEG_BLANK=7'h00;
  - a typedef for a 7-bit segment pattern.
- Sub-module seg_pattern_decode, purely combinational.
  - Inputs: pattern[6:0].
  - Outputs: nibble[3:0], hit, blank.
  - Built from the package constants and reusable by other blocks.
- Synchroniser, stability counter, capture and frame logic live in seg_scan_decoder itself.

Test Plan:
- Reset: assert rst_n=0 mid-dwell → all outputs 0 asynchronously; after release with unchanged inputs, capture occurs only after a full STABLE_CYCLES+2 dwell.
- Single digit: STABLE_CYCLES=4, NUM_DIGITS=4, dig_in=4'b0010, seg_in=7'h6D held → exactly 6 clocks later digits_out[7:4]=2, digit_valid=4'b0010, update_pulse high for 1 cycle; holding for 100 more cycles produces no further pulse.
- Full frame: scan digits 0..3 with patterns 79, 33, 5B, 47, each held 10 cycles → digits_out=16'hF543, digit_valid=4'hF, frame_done pulses once, coincident with the digit-3 capture.
- Errors and blanks: digit 1 gets 7'h01 → digit_err=4'b0010, digit_valid[1]=0, nibble unchanged; then 7'h00 → digit_err[1]=0, digit_valid[1]=0.
- Illegal select and glitches:
  - dig_in=4'b0110 held 20 cycles → no capture.
  - A 3-cycle segment glitch with STABLE_CYCLES=4 → no capture.
  - Return to the prior stable value → one new capture.
- Polarity: SEG_ACTIVE_LOW=1, DIG_ACTIVE_LOW=1, seg_in=~7'h7F, dig_in=4'b1110 → digits_out[3:0]=8, digit_valid[0]=1.
